// File: rtl/kernel_conv_driver.sv
// Initiator-side driver for one convolution compute kernel: latches a window,
// sequences start/capture/clear/done, and emits raster-tagged result pixels.
module kernel_conv_driver #(
   parameter int MAX_KERNEL = 3,
   parameter int IMG_W      = 64,
   parameter int IMG_H      = 64,
   parameter int TIMEOUT    = 64
) (
   input  logic                                          clk,
   input  logic                                          n_rst,
   input  logic                                          win_valid,
   output logic                                          win_ready,
   input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]    win_matrix,
   input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]    win_kernel,
   input  logic [$clog2(MAX_KERNEL)-1:0]                 win_ksize,
   output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]    ck_matrix,
   output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]    ck_kernel,
   output logic [$clog2(MAX_KERNEL)-1:0]                 ck_ksize,
   output logic                                          ck_start,
   output logic                                          ck_clear,
   input  logic                                          ck_clear_signal,
   input  logic                                          ck_done,
   input  logic [7:0]                                    ck_pixel,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [7:0]                                    out_pixel,
   output logic [$clog2(IMG_W)-1:0]                      out_x,
   output logic [$clog2(IMG_H)-1:0]                      out_y,
   output logic                                          out_last,
   output logic                                          err_timeout
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int KW = $clog2(MAX_KERNEL);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
   localparam logic [CW-1:0] C_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_CLR,
      S_CLEAR,
      S_OUTPUT
   } state_t;

   state_t                                     r_state;
   logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_matrix;
   logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_kernel;
   logic [KW-1:0]                              r_ksize;
   logic                                       r_win_ready;
   logic                                       r_start;
   logic                                       r_clear;
   logic                                       r_out_valid;
   logic [7:0]                                 r_pixel;
   logic [XW-1:0]                              r_x;
   logic [YW-1:0]                              r_y;
   logic [CW-1:0]                              r_cnt;
   logic                                       r_err;
   logic                                       w_abort;

   // A done arriving in the last allowed CLEAR cycle still completes the window.
   always_comb begin
      w_abort = 1'b0;
      if (r_cnt == C_MAX) begin
         w_abort = (r_state == S_START) || (r_state == S_WAIT_CLR) ||
                   ((r_state == S_CLEAR) && !ck_done);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_matrix    <= '0;
         r_kernel    <= '0;
         r_ksize     <= '0;
         r_win_ready <= 1'b1;
         r_start     <= 1'b0;
         r_clear     <= 1'b0;
         r_out_valid <= 1'b0;
         r_pixel     <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_start <= 1'b0;
         if (w_abort) begin
            r_err       <= 1'b1;
            r_clear     <= 1'b0;
            r_win_ready <= 1'b1;
            r_state     <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (win_valid) begin
                     r_matrix    <= win_matrix;
                     r_kernel    <= win_kernel;
                     r_ksize     <= win_ksize;
                     r_win_ready <= 1'b0;
                     r_start     <= 1'b1;
                     r_cnt       <= '0;
                     r_state     <= S_START;
                  end
               end
               S_START: begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_state <= S_WAIT_CLR;
               end
               S_WAIT_CLR: begin
                  r_cnt <= r_cnt + CW'(1);
                  if (ck_clear_signal) begin
                     r_pixel <= ck_pixel;
                     r_clear <= 1'b1;
                     r_state <= S_CLEAR;
                  end
               end
               S_CLEAR: begin
                  r_cnt <= r_cnt + CW'(1);
                  if (ck_done) begin
                     r_clear     <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_OUTPUT;
                  end
               end
               S_OUTPUT: begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     r_win_ready <= 1'b1;
                     r_state     <= S_IDLE;
                     if (r_x == X_MAX) begin
                        r_x <= '0;
                        r_y <= (r_y == Y_MAX) ? '0 : r_y + YW'(1);
                     end else begin
                        r_x <= r_x + XW'(1);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign win_ready   = r_win_ready;
   assign ck_matrix   = r_matrix;
   assign ck_kernel   = r_kernel;
   assign ck_ksize    = r_ksize;
   assign ck_start    = r_start;
   assign ck_clear    = r_clear;
   assign out_valid   = r_out_valid;
   assign out_pixel   = r_pixel;
   assign out_x       = r_x;
   assign out_y       = r_y;
   assign out_last    = r_out_valid && (r_x == X_MAX) && (r_y == Y_MAX);
   assign err_timeout = r_err;

endmodule

// File: doc/kernel_conv_driver.md
# kernel_conv_driver

Drives one convolution compute-kernel instance, the initiator side of its start/clear/done handshake. Windows arrive from the line-buffer side over valid/ready. Each window is latched and held stable on the kernel's matrix inputs, then sequenced through start, result capture, clear and done. Each result is emitted as a raster-tagged pixel over valid/ready. It sits between the window generator and the output pixel writer of the blur/ISP pipeline.

## Interface
- MAX_KERNEL, 3, maximum kernel dimension; sets matrix port sizes.
- IMG_W, 64, output image width in pixels.
- IMG_H, 64, output image height in pixels.
- TIMEOUT, 64, maximum cycles from ck_start to ck_done before the block aborts the window.
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- win_valid  in  1  upstream window valid.
- win_ready  out  1  block can accept a window.
- win_matrix  in  [MAX_KERNEL][MAX_KERNEL][8]  pixel window.
- win_kernel  in  [MAX_KERNEL][MAX_KERNEL][8]  kernel coefficients.
- win_ksize  in  $clog2(MAX_KERNEL)  active kernel size.
- ck_matrix, ck_kernel  out  same as win_*  latched window and kernel to the compute kernel.
- ck_ksize  out  $clog2(MAX_KERNEL)  latched kernel size.
- ck_start  out  1  start pulse to the compute kernel.
- ck_clear  out  1  accumulator clear request.
- ck_clear_signal  in  1  compute kernel reports its result is complete and requests a clear.
- ck_done  in  1  one-cycle completion pulse from the compute kernel.
- ck_pixel  in  8  compute kernel result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_pixel  out  8  captured result.
- out_x  out  $clog2(IMG_W)  result column.
- out_y  out  $clog2(IMG_H)  result row.
- out_last  out  1  high with the result at (IMG_W-1, IMG_H-1).
- err_timeout  out  1  sticky; set when a window is aborted.

## Operation
- FSM states and transitions:
  - IDLE: win_ready=1. On win_valid, latch win_matrix, win_kernel and win_ksize into the ck_* registers, then go to START.
  - START: ck_start=1 for exactly this cycle. Go to WAIT_CLR.
  - WAIT_CLR: wait for ck_clear_signal. In the cycle it is seen high, capture ck_pixel into out_pixel and go to CLEAR.
  - CLEAR: ck_clear=1 every cycle in this state. When ck_done is seen high, go to OUTPUT.
  - OUTPUT: out_valid=1; all out_* held stable. On out_ready, advance the coordinates and go to IDLE.
- ck_* matrix, kernel and size registers change only at window acceptance. They are stable through START..OUTPUT.
- Coordinates advance raster-order: x++. When x=IMG_W-1, x wraps to 0 and y++. After (IMG_W-1, IMG_H-1) both wrap to 0.
- out_last is combinational: out_valid && x==IMG_W-1 && y==IMG_H-1.
- Timeout counter:
  - Clears on entering START and increments each cycle in START, WAIT_CLR and CLEAR.
  - Reaching TIMEOUT without having left CLEAR triggers an abort: err_timeout=1 (sticky until reset), ck_clear deasserts, FSM goes to IDLE.
  - The aborted window produces no output and coordinates do not advance.
- ck_done seen in any state other than CLEAR is ignored.
- ck_clear_signal seen outside WAIT_CLR is ignored.
- No overlap: win_ready is low whenever out_valid is high.

## Timing
- Reset (n_rst=0 at a clk edge): FSM goes to IDLE. Every output is then 0 except win_ready=1. This includes ck_* registers, out_pixel, out_x/out_y, counters and err_timeout. Reset applies mid-operation with no output produced.
- Acceptance at edge k ⇒ ck_start high during cycle k+1 only, then low for at least one cycle before any later start.
- ck_clear_signal first high in cycle c ⇒ out_pixel = ck_pixel sampled at edge c; ck_clear high from cycle c+1.
- ck_done high in cycle d (while in CLEAR) ⇒ ck_clear low and out_valid high from cycle d+1.
- Handshake at edge o (out_valid && out_ready) ⇒ win_ready high in cycle o+1. A new window can be accepted at edge o+1.
- Driver overhead per window, excluding compute-kernel latency and out_ready stall: 1 accept + 1 start + 1 capture + 1 output cycle.

## Test plan
- Single window, behavioural compute-kernel model producing result 0x5A: ck_start is a 1-cycle pulse after acceptance; out_pixel=0x5A; out_x=0, out_y=0; ck_clear high until ck_done, then drops.
- Full frame with IMG_W=4, IMG_H=2 (8 windows) and out_ready always 1: coordinates run (0,0)…(3,1); out_last only on the 8th result; the 9th result is at (0,0).
- Backpressure: out_ready low for 10 cycles: out_valid, out_pixel and coordinates held; win_ready=0 with win_valid=1; ck_matrix unchanged when win_matrix changes.
- Timeout: model never raises ck_done, TIMEOUT=16: err_timeout rises and stays 1; FSM returns to IDLE; next window reuses the same coordinates.
- Reset mid-CLEAR: all outputs are at reset values the cycle after reset; a following window completes normally at (0,0).
- Spurious ck_done during WAIT_CLR: ignored; the result comes from the later clear_signal/done sequence.
